// File: rtl/fir_cap_pkg.sv
// Shared types and default parameters for the FIR output capture engine.
package fir_cap_pkg;

  localparam int unsigned N_TAPS_DEF = 1;
  localparam int unsigned BW_OUT_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    CAPT = 2'd2
  } cap_state_t;

endpackage

// File: rtl/fir_cap_fifo.sv
// Synchronous FIFO buffering captured samples for the host stream.
// Ports: clk, rst (async active-low), push/data (write), pop (read request),
//        head (oldest entry), m_valid (non-empty), full, level (occupancy).
module fir_cap_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     m_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO only succeeds when a pop frees a slot on the same edge.
  always_comb begin
    do_pop  = pop & m_valid;
    do_push = push & (~full | do_pop);
    wr_nxt  = wr_ptr + PW'(do_push);
    rd_nxt  = rd_ptr + PW'(do_pop);
  end

  // Status flags are derived from the next pointers so they are registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      m_valid <= 1'b0;
      full    <= 1'b0;
      level   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      if (do_push) mem[wr_ptr[AW-1:0]] <= data;
      level   <= wr_nxt - rd_nxt;
      m_valid <= (wr_nxt != rd_nxt);
      full    <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fir_out_capture.sv
// Capture engine on the FIR filter output pins: skips the pipeline-fill
// samples, buffers the next `count` samples and streams them out.
// Ports: clk, rst (async active-low), start/skip/count (capture request),
//        io_out (filter pins), m_data/m_valid/m_ready (output stream),
//        busy, done (end-of-capture pulse), overflow (sticky drop), level.
module fir_out_capture
  import fir_cap_pkg::*;
#(
  parameter int unsigned N_TAPS = N_TAPS_DEF,
  parameter int unsigned BW_out = BW_OUT_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       skip,
  input  logic [CNT_W-1:0]       count,
  input  logic [7:0]             io_out,
  output logic [BW_out-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  // Reject parameter sets the FIFO pointer scheme cannot support.
  if (N_TAPS < 1 || BW_out < 1 || BW_out > 8 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("fir_out_capture: illegal parameter set");
  end

  cap_state_t        state;
  logic [CNT_W-1:0]  skip_cnt;
  logic [CNT_W-1:0]  cap_cnt;
  logic              push;
  logic              fifo_full;

  assign push = (state == CAPT);

  fir_cap_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BW_out)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .data    (io_out[BW_out-1:0]),
    .pop     (m_ready),
    .head    (m_data),
    .m_valid (m_valid),
    .full    (fifo_full),
    .level   (level)
  );

  // Control FSM: counters hold the remaining samples and exit on the terminal one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      skip_cnt <= '0;
      cap_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      // A drop happens only when full with no pop freeing a slot on this edge.
      if (push && fifo_full && !(m_ready && m_valid)) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            skip_cnt <= skip;
            cap_cnt  <= count;
            overflow <= 1'b0;
            if (skip != '0) begin
              state <= SKIP;
              busy  <= 1'b1;
            end else if (count != '0) begin
              state <= CAPT;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SKIP: begin
          if (skip_cnt == CNT_W'(1)) begin
            if (cap_cnt != '0) begin
              state <= CAPT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            skip_cnt <= skip_cnt - CNT_W'(1);
          end
        end
        CAPT: begin
          if (cap_cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cap_cnt <= cap_cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_out_capture.sv
// Scoreboard bench for fir_out_capture: stimulus pushes expected samples,
// a negedge monitor compares every accepted stream beat.
module tb_fir_out_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] skip;
  logic [7:0] count;
  logic [7:0] io_out;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [3:0] level;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  fir_out_capture #(
    .N_TAPS (1),
    .BW_out (8),
    .DEPTH  (8),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .skip     (skip),
    .count    (count),
    .io_out   (io_out),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 60) begin
      step();
      n++;
    end
    chk({name, "_drain_bound"}, 32'(n < 60), 32'd1);
    chk({name, "_level_empty"}, 32'(level), 32'd0);
  endtask

  // Monitor: a beat is accepted on the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", m_data);
      end else begin
        if (m_data !== exp_q[0]) begin
          failures++;
          $display("FAIL stream_data actual=%0h required=%0h", m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; skip = '0; count = '0; io_out = '0; m_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    // Idle after reset: everything stays at zero.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_flags", 32'({m_valid, busy, done, overflow, level}), 32'd0);
    end
    chk("idle_mdata", 32'(m_data), 32'd0);

    // skip=3, count=4 with ramp: stream 3,4,5,6.
    m_ready = 1'b1; skip = 8'd3; count = 8'd4; start = 1'b1;
    for (int v = 3; v <= 6; v++) exp_q.push_back(8'(v));
    step();
    start = 1'b0; io_out = 8'd0;
    chk("t2_busy_rise", 32'(busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      io_out = 8'(i);
      chk("t2_done", 32'(done), 32'(i == 7));
      chk("t2_busy", 32'(busy), 32'(i < 7));
    end
    chk("t2_overflow", 32'(overflow), 32'd0);
    drain("t2");

    // count=10 into an 8-deep FIFO with no consumer: two samples dropped.
    m_ready = 1'b0; skip = 8'd0; count = 8'd10; start = 1'b1;
    for (int v = 16; v < 24; v++) exp_q.push_back(8'(v));
    step();
    start = 1'b0; io_out = 8'h10;
    for (int i = 1; i <= 10; i++) begin
      step();
      io_out = 8'(16 + i);
      chk("t3_level", 32'(level), 32'((i < 8) ? i : 8));
      chk("t3_overflow", 32'(overflow), 32'(i >= 9));
      chk("t3_done", 32'(done), 32'(i == 10));
    end
    m_ready = 1'b1;
    drain("t3");
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous pop: no drop, level holds at 8.
    m_ready = 1'b0; skip = 8'd0; count = 8'd12; start = 1'b1;
    for (int v = 32; v < 44; v++) exp_q.push_back(8'(v));
    step();
    start = 1'b0; io_out = 8'h20;
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      io_out = 8'(32 + i);
      if (i == 8) m_ready = 1'b1;
      chk("t4_level", 32'(level), 32'((i < 8) ? i : 8));
      chk("t4_overflow", 32'(overflow), 32'd0);
      chk("t4_done", 32'(done), 32'(i == 12));
    end
    drain("t4");

    // Zero-length capture: done next cycle, no push.
    skip = 8'd0; count = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_done_pulse", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    step();
    chk("t5_done_clear", 32'(done), 32'd0);

    // Second start while busy is ignored.
    m_ready = 1'b1; skip = 8'd2; count = 8'd3; start = 1'b1;
    for (int v = 66; v <= 68; v++) exp_q.push_back(8'(v));
    step();
    io_out = 8'h40; skip = 8'd5; count = 8'd1;
    chk("t5b_busy_rise", 32'(busy), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      step();
      start = 1'b0;
      io_out = 8'(64 + i);
      chk("t5b_done", 32'(done), 32'(i == 5));
      chk("t5b_busy", 32'(busy), 32'(i < 5));
    end
    drain("t5b");

    // Reset mid-capture with three entries buffered.
    m_ready = 1'b0; skip = 8'd0; count = 8'd6; start = 1'b1;
    step();
    start = 1'b0; io_out = 8'h50;
    for (int i = 1; i <= 3; i++) begin
      step();
      io_out = 8'(80 + i);
    end
    chk("t6_level_pre", 32'(level), 32'd3);
    rst = 1'b0;
    #1;
    chk("t6_rst_flags", 32'({m_valid, busy, done, overflow, level}), 32'd0);
    step();
    step();
    chk("t6_rst_hold", 32'({m_valid, busy, done, overflow, level}), 32'd0);
    rst = 1'b1;
    step();
    m_ready = 1'b1; skip = 8'd1; count = 8'd2; start = 1'b1;
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    step();
    start = 1'b0; io_out = 8'h60;
    for (int i = 1; i <= 4; i++) begin
      step();
      io_out = 8'(96 + i);
      chk("t6_done", 32'(done), 32'(i == 3));
    end
    drain("t6");
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
